// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter run controller.
//   - run_state_e    : STOP / RUN state encoding
//   - DEF_*          : default divider, debounce and counter-width values
//   - presc_width()  : prescaler register width needed for the larger divider
package counter_ctrl_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_FAST_DIV   = 200000;
  localparam int DEF_SLOW_DIV   = 20000000;
  localparam int DEF_DEB_CYCLES = 500000;

  // The prescaler only ever holds 0 .. DIV-1, so clog2 of the larger divider
  // is enough. Both dividers are at least 2, so the result is at least 1.
  function automatic int presc_width(input int fast_div, input int slow_div);
    int m;
    m = (fast_div > slow_div) ? fast_div : slow_div;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, accepted
// level and a one-cycle press pulse on an accepted 0->1 transition.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high
//   btn_raw_i  raw asynchronous button level, high = pressed
//   press_o    one-cycle pulse per accepted press (release gives no pulse)
module button_conditioner #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  // The counter holds the number of consecutive mismatch cycles already seen;
  // the DEB_CYCLES-th mismatch flips the accepted level. A matching cycle
  // clears the count, so any gap restarts the qualification.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      level_prev_q <= level_q;
      // Edge detect on the registered level keeps the pulse fully registered;
      // the press reaches the FSM DEB_CYCLES+3 edges after the pin rises.
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/counter_run_controller.sv
// Run/step controller for the up/down display counter, using clock enables.
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   btn_run_raw  raw start/stop button (high = pressed)
//   btn_dir_raw  raw direction button (high = pressed)
//   speed_fast   1 = step every FAST_DIV cycles, 0 = every SLOW_DIV cycles
//   bounce_en    1 = reverse direction at the count limits
//   count_in     current counter value from the datapath
//   step         one-cycle pulse: counter moves one position
//   step_up      direction of the step (1 = increment), valid with step
//   running      1 while in RUN
//   dir_up       current direction state
module counter_run_controller
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FAST_DIV   = DEF_FAST_DIV,
  parameter int SLOW_DIV   = DEF_SLOW_DIV,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_run_raw,
  input  logic             btn_dir_raw,
  input  logic             speed_fast,
  input  logic             bounce_en,
  input  logic [CNT_W-1:0] count_in,
  output logic             step,
  output logic             step_up,
  output logic             running,
  output logic             dir_up
);

  localparam int PW      = presc_width(FAST_DIV, SLOW_DIV);
  localparam int BTN_RUN = 0;
  localparam int BTN_DIR = 1;

  logic [1:0] btn_raw;
  logic [1:0] btn_press;

  assign btn_raw = {btn_dir_raw, btn_run_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      button_conditioner #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_btn (
        .clk      (clk),
        .reset    (reset),
        .btn_raw_i(btn_raw[gi]),
        .press_o  (btn_press[gi])
      );
    end
  endgenerate

  logic spd_s1_q, spd_s2_q;
  logic bnc_s1_q, bnc_s2_q;

  run_state_e    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          step_q, step_d;
  logic          step_up_q, step_up_d;

  logic          run_press, dir_press;
  logic          speed_chg;
  logic [PW-1:0] term_val;
  logic          tick;
  logic          eff_dir;

  assign run_press = btn_press[BTN_RUN];
  assign dir_press = btn_press[BTN_DIR];

  // The value about to enter the second stage differs from the one in use:
  // the synchronised speed changes on this edge, so the prescaler restarts
  // together with the new divider.
  assign speed_chg = spd_s1_q ^ spd_s2_q;
  assign term_val  = spd_s2_q ? PW'(FAST_DIV - 1) : PW'(SLOW_DIV - 1);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    step_up_d = step_up_q;
    tick      = 1'b0;
    eff_dir   = dir_q;

    case (state_q)
      ST_STOP: begin
        presc_d = '0;
        if (run_press) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Stop has priority over a terminal tick, so no step is issued.
        if (run_press) begin
          state_d = ST_STOP;
          presc_d = '0;
        end else if (speed_chg) begin
          presc_d = '0;
        end else if (presc_q == term_val) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STOP;
        presc_d = '0;
      end
    endcase

    // Bounce reversal first, then a direction press toggles the result, so a
    // coincident press and reversal cancel out.
    if (tick && bnc_s2_q) begin
      if (dir_q && (count_in == '1)) begin
        eff_dir = 1'b0;
      end else if (!dir_q && (count_in == '0)) begin
        eff_dir = 1'b1;
      end
    end
    if (dir_press) begin
      eff_dir = ~eff_dir;
    end
    dir_d = eff_dir;

    if (tick) begin
      step_d    = 1'b1;
      step_up_d = eff_dir;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spd_s1_q  <= 1'b0;
      spd_s2_q  <= 1'b0;
      bnc_s1_q  <= 1'b0;
      bnc_s2_q  <= 1'b0;
      state_q   <= ST_STOP;
      presc_q   <= '0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      step_up_q <= 1'b1;
    end else begin
      spd_s1_q  <= speed_fast;
      spd_s2_q  <= spd_s1_q;
      bnc_s1_q  <= bounce_en;
      bnc_s2_q  <= bnc_s1_q;
      state_q   <= state_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      step_up_q <= step_up_d;
    end
  end

  assign step    = step_q;
  assign step_up = step_up_q;
  assign running = (state_q == ST_RUN);
  assign dir_up  = dir_q;

endmodule
